// File: rtl/buffered_matrix_window_generator.sv
`timescale 1ns/1ps
// Streams RGB pixels, converts them to grayscale and keeps K-1 lines so that a KxK
// window (optionally without its centre) comes out three cycles after each pixel.
module buffered_matrix_window_generator #(
  parameter int P_FRAME_COLUMNS  = 640,
  parameter int P_FRAME_ROWS     = 480,
  parameter int P_PIXEL_DEPTH    = 24,
  parameter int P_WINDOW_SIZE    = 3,
  parameter int P_INCLUDE_CENTER = 0,
  parameter int P_GRAYSCALE      = 1,
  localparam int D   = P_PIXEL_DEPTH / 3,
  localparam int K   = P_WINDOW_SIZE,
  localparam int N   = K * K - ((P_INCLUDE_CENTER != 0) ? 0 : 1),
  localparam int P_MATRIX_BITS = D * N,
  localparam int CW  = $clog2(P_FRAME_COLUMNS),
  localparam int RW  = $clog2(P_FRAME_ROWS)
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET_N,
  input  logic                     I_DATA_VALID,
  input  logic                     I_SOF,
  input  logic [P_PIXEL_DEPTH-1:0] I_PIXEL,
  output logic [CW-1:0]            O_PIXEL_COLUMN,
  output logic [RW-1:0]            O_PIXEL_ROW,
  output logic [P_MATRIX_BITS-1:0] O_PIXEL_MATRIX,
  output logic                     O_PIXEL_MATRIX_VALID,
  output logic                     O_FRAME_DONE
);

  localparam int CTR = (K * K) / 2;

  if ((P_PIXEL_DEPTH % 3) != 0 || K < 3 || (K % 2) == 0 ||
      K > P_FRAME_ROWS || K > P_FRAME_COLUMNS) begin : g_bad_param
    $error("buffered_matrix_window_generator: illegal parameter combination");
  end

  // input position counters
  logic [CW-1:0] cnt_col_q, cnt_col_d, pix_col;
  logic [RW-1:0] cnt_row_q, cnt_row_d, pix_row;

  always_comb begin
    pix_col   = I_SOF ? '0 : cnt_col_q;
    pix_row   = I_SOF ? '0 : cnt_row_q;
    cnt_col_d = cnt_col_q;
    cnt_row_d = cnt_row_q;
    if (I_DATA_VALID) begin
      if (pix_col == CW'(P_FRAME_COLUMNS - 1)) begin
        cnt_col_d = '0;
        cnt_row_d = (pix_row == RW'(P_FRAME_ROWS - 1)) ? '0 : pix_row + 1'b1;
      end else begin
        cnt_col_d = pix_col + 1'b1;
        cnt_row_d = pix_row;
      end
    end
  end

  // luma weights sum to 256, so the shifted result always fits D bits
  logic [D-1:0] sub_r, sub_g, sub_b, gray;
  logic [D+8:0] luma;
  assign sub_r = I_PIXEL[3*D-1:2*D];
  assign sub_g = I_PIXEL[2*D-1:D];
  assign sub_b = I_PIXEL[D-1:0];
  assign luma  = (D+9)'(77)  * (D+9)'(sub_r) +
                 (D+9)'(150) * (D+9)'(sub_g) +
                 (D+9)'(29)  * (D+9)'(sub_b);
  assign gray  = (P_GRAYSCALE != 0) ? D'(luma >> 8) : sub_g;

  // vld_pipe[0]: pixel in stage 1, [1]: window in stage 2, [2]: output valid
  logic [2:0]    vld_pipe_q, vld_pipe_d;
  logic [D-1:0]  s1_gray_q, s1_gray_d;
  logic [CW-1:0] s1_col_q, s1_col_d;
  logic [RW-1:0] s1_row_q, s1_row_d;

  always_comb begin
    s1_gray_d = I_DATA_VALID ? gray    : s1_gray_q;
    s1_col_d  = I_DATA_VALID ? pix_col : s1_col_q;
    s1_row_d  = I_DATA_VALID ? pix_row : s1_row_q;
  end

  logic [K-2:0][P_FRAME_COLUMNS-1:0][D-1:0] lb_q, lb_d;
  logic [K-1:0][K-1:0][D-1:0]               win_q, win_d;
  logic [K-1:0][D-1:0]                      new_col;
  logic                                     win_ok;
  logic [CW-1:0]                            s2_col_q, s2_col_d;
  logic [RW-1:0]                            s2_row_q, s2_row_d;
  logic                                     s2_done_q, s2_done_d;

  always_comb begin
    lb_d      = lb_q;
    win_d     = win_q;
    new_col   = '0;
    s2_col_d  = s2_col_q;
    s2_row_d  = s2_row_q;
    s2_done_d = s2_done_q;
    win_ok    = (s1_col_q >= CW'(K - 1)) && (s1_row_q >= RW'(K - 1));
    if (vld_pipe_q[0]) begin
      // oldest buffered line sits at the top of the new column
      for (int r = 0; r < K - 1; r++) new_col[r] = lb_q[K-2-r][s1_col_q];
      new_col[K-1] = s1_gray_q;
      for (int i = K - 2; i > 0; i--) lb_d[i][s1_col_q] = lb_q[i-1][s1_col_q];
      lb_d[0][s1_col_q] = s1_gray_q;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = new_col[r];
      end
      if (win_ok) begin
        s2_col_d  = s1_col_q - CW'(K - 1);
        s2_row_d  = s1_row_q - RW'(K - 1);
        s2_done_d = (s1_col_q == CW'(P_FRAME_COLUMNS - 1)) &&
                    (s1_row_q == RW'(P_FRAME_ROWS - 1));
      end
    end
    vld_pipe_d = {vld_pipe_q[1], vld_pipe_q[0] & win_ok, I_DATA_VALID};
  end

  logic [P_MATRIX_BITS-1:0] flat, mat_q, mat_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     done_q, done_d;
  int                       k, p;

  // row-major packing, top-left entry in the MSBs
  always_comb begin
    flat = '0;
    k    = 0;
    p    = 0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        k = r * K + c;
        if (P_INCLUDE_CENTER != 0 || k != CTR) begin
          p = (P_INCLUDE_CENTER != 0 || k < CTR) ? k : k - 1;
          flat[(N-1-p)*D +: D] = win_q[r][c];
        end
      end
    end
  end

  always_comb begin
    mat_d  = vld_pipe_q[1] ? flat     : mat_q;
    col_d  = vld_pipe_q[1] ? s2_col_q : col_q;
    row_d  = vld_pipe_q[1] ? s2_row_q : row_q;
    done_d = vld_pipe_q[1] & s2_done_q;
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      cnt_col_q  <= '0;
      cnt_row_q  <= '0;
      vld_pipe_q <= '0;
      s1_gray_q  <= '0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      lb_q       <= '0;
      win_q      <= '0;
      s2_col_q   <= '0;
      s2_row_q   <= '0;
      s2_done_q  <= 1'b0;
      mat_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      cnt_col_q  <= cnt_col_d;
      cnt_row_q  <= cnt_row_d;
      vld_pipe_q <= vld_pipe_d;
      s1_gray_q  <= s1_gray_d;
      s1_col_q   <= s1_col_d;
      s1_row_q   <= s1_row_d;
      lb_q       <= lb_d;
      win_q      <= win_d;
      s2_col_q   <= s2_col_d;
      s2_row_q   <= s2_row_d;
      s2_done_q  <= s2_done_d;
      mat_q      <= mat_d;
      col_q      <= col_d;
      row_q      <= row_d;
      done_q     <= done_d;
    end
  end

  assign O_PIXEL_MATRIX       = mat_q;
  assign O_PIXEL_COLUMN       = col_q;
  assign O_PIXEL_ROW          = row_q;
  assign O_PIXEL_MATRIX_VALID = vld_pipe_q[2];
  assign O_FRAME_DONE         = done_q;

endmodule
